// File: rtl/placement_engine.sv
// Graph placement engine: edge ROM (1-cycle read) -> LFSR random-walk placement -> wire cost; start/busy/done|fail, no backpressure.
// Build with ONEHOP_EVAL_EN defined to also accumulate cost_1hop; otherwise cost_1hop is tied to 0.
module placement_engine #(
  parameter int N_NODES   = 16,
  parameter int N_EDGES   = 32,
  parameter int GRID_W    = 8,
  parameter int GRID_H    = 8,
  parameter int MAX_TRIES = 64,
  parameter int CW        = 32,
  localparam int NW = (N_NODES > 1) ? $clog2(N_NODES) : 1,
  localparam int EW = (N_EDGES > 1) ? $clog2(N_EDGES) : 1
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          start,
  input  logic [31:0]   seed_in,
  output logic          edge_rd,
  output logic [EW-1:0] edge_addr,
  input  logic [NW-1:0] edge_a,
  input  logic [NW-1:0] edge_b,
  output logic          busy,
  output logic          done,
  output logic          fail,
  output logic [CW-1:0] cost,
  output logic [CW-1:0] cost_1hop,
  output logic [CW-1:0] cycles
);

  localparam int XW    = (GRID_W > 1) ? $clog2(GRID_W) : 1;
  localparam int YW    = (GRID_H > 1) ? $clog2(GRID_H) : 1;
  localparam int NCELL = GRID_W * GRID_H;
  localparam int CIW   = (NCELL > 1) ? $clog2(NCELL) : 1;
  localparam int TW    = $clog2(MAX_TRIES + 1);

  typedef enum logic [3:0] {
    S_IDLE, S_CLEAR, S_FETCH, S_LATCH, S_PLACE,
    S_EVAL_FETCH, S_EVAL_LAT, S_EVAL_ACC, S_DONE, S_FAIL
  } state_t;

  state_t state, state_nxt;

  logic [31:0]        lfsr;
  logic [NW-1:0]      clr_idx;
  logic [NW-1:0]      cur_a;
  logic [NW-1:0]      cur_b;
  logic [EW-1:0]      edge_idx;
  logic [TW-1:0]      tries;
  logic [N_NODES-1:0] placed;
  logic [NCELL-1:0]   occ;
  logic [XW-1:0]      pos_x [N_NODES];
  logic [YW-1:0]      pos_y [N_NODES];

  logic edge_last, clr_last, try_last;
  assign edge_last = (edge_idx == EW'(N_EDGES - 1));
  assign clr_last  = (clr_idx == NW'(N_NODES - 1));
  assign try_last  = (tries == TW'(MAX_TRIES - 1));

  function automatic logic [31:0] lfsr_next(input logic [31:0] v);
    return (v >> 1) ^ (v[0] ? 32'h8020_0003 : 32'h0);
  endfunction

  // Candidate cell for the current PLACE cycle: random cell if neither end
  // is placed, otherwise a walk of radius 1+tries/4 away from the anchor.
  logic            pa, pb, both, neither;
  logic [NW-1:0]   tgt, anc;
  logic [31:0]     p_mx, p_my;
  int              p_rr, p_nx, p_ny, p_cell;
  logic            p_inb;
  logic [XW-1:0]   cand_x;
  logic [YW-1:0]   cand_y;
  logic [CIW-1:0]  cand_cell;
  logic            cand_ok;
  logic            edge_placed;

  always_comb begin
    pa      = placed[cur_a];
    pb      = placed[cur_b];
    both    = pa & pb;
    neither = ~pa & ~pb;
    anc     = pa ? cur_a : cur_b;
    tgt     = pa ? cur_b : cur_a;
    p_mx    = 32'(lfsr[15:0]) % 32'(GRID_W);
    p_my    = 32'(lfsr[31:16]) % 32'(GRID_H);
    p_rr    = 1 + int'(tries >> 2);
    p_nx    = int'(pos_x[anc]);
    p_ny    = int'(pos_y[anc]);
    case (lfsr[1:0])
      2'd0:    p_nx = p_nx + p_rr;
      2'd1:    p_nx = p_nx - p_rr;
      2'd2:    p_ny = p_ny + p_rr;
      default: p_ny = p_ny - p_rr;
    endcase
    if (neither) begin
      p_nx = int'(p_mx);
      p_ny = int'(p_my);
    end
    p_inb       = (p_nx >= 0) && (p_nx < GRID_W) && (p_ny >= 0) && (p_ny < GRID_H);
    p_cell      = p_inb ? (p_ny * GRID_W + p_nx) : 0;
    cand_x      = XW'(p_nx);
    cand_y      = YW'(p_ny);
    cand_cell   = CIW'(p_cell);
    cand_ok     = p_inb && !occ[cand_cell] && !both;
    edge_placed = both || (!neither && cand_ok);
  end

  int            e_dx, e_dy;
  logic [CW-1:0] ev_cost;

  always_comb begin
    e_dx = int'(pos_x[cur_a]) - int'(pos_x[cur_b]);
    e_dy = int'(pos_y[cur_a]) - int'(pos_y[cur_b]);
    if (e_dx < 0) e_dx = -e_dx;
    if (e_dy < 0) e_dy = -e_dy;
    ev_cost = CW'(e_dx + e_dy - 1);
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state <= S_IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE:       if (start) state_nxt = S_CLEAR;
      S_CLEAR:      if (clr_last) state_nxt = S_FETCH;
      S_FETCH:      state_nxt = S_LATCH;
      S_LATCH:      state_nxt = S_PLACE;
      S_PLACE: begin
        if (edge_placed)                 state_nxt = edge_last ? S_EVAL_FETCH : S_FETCH;
        else if (!cand_ok && try_last)   state_nxt = S_FAIL;
      end
      S_EVAL_FETCH: state_nxt = S_EVAL_LAT;
      S_EVAL_LAT:   state_nxt = S_EVAL_ACC;
      S_EVAL_ACC:   state_nxt = edge_last ? S_DONE : S_EVAL_FETCH;
      S_DONE:       state_nxt = S_IDLE;
      S_FAIL:       state_nxt = S_IDLE;
      default:      state_nxt = S_IDLE;
    endcase
  end

  always_comb begin
    edge_rd = (state == S_FETCH) || (state == S_EVAL_FETCH);
  end

  assign edge_addr = edge_idx;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      lfsr     <= 32'd1;
      busy     <= 1'b0;
      done     <= 1'b0;
      fail     <= 1'b0;
      cost     <= '0;
      cycles   <= '0;
      clr_idx  <= '0;
      edge_idx <= '0;
      tries    <= '0;
      cur_a    <= '0;
      cur_b    <= '0;
      placed   <= '0;
      occ      <= '0;
    end else begin
      if (busy) begin
        lfsr   <= lfsr_next(lfsr);
        cycles <= cycles + 1'b1;
      end
      case (state)
        S_IDLE: if (start) begin
          lfsr     <= (seed_in == 32'd0) ? 32'd1 : seed_in;
          cost     <= '0;
          cycles   <= '0;
          done     <= 1'b0;
          fail     <= 1'b0;
          busy     <= 1'b1;
          clr_idx  <= '0;
          edge_idx <= '0;
        end
        S_CLEAR: begin
          placed[clr_idx] <= 1'b0;
          occ             <= '0;
          clr_idx         <= clr_idx + 1'b1;
        end
        S_LATCH, S_EVAL_LAT: begin
          cur_a <= edge_a;
          cur_b <= edge_b;
          tries <= '0;
        end
        S_PLACE: begin
          if (cand_ok) begin
            placed[tgt]    <= 1'b1;
            occ[cand_cell] <= 1'b1;
            tries          <= '0;
          end else if (!both) begin
            tries <= tries + 1'b1;
          end
          if (edge_placed) edge_idx <= edge_last ? '0 : edge_idx + 1'b1;
        end
        S_EVAL_ACC: begin
          cost     <= cost + ev_cost;
          edge_idx <= edge_last ? '0 : edge_idx + 1'b1;
        end
        S_DONE: begin
          done <= 1'b1;
          busy <= 1'b0;
        end
        S_FAIL: begin
          fail <= 1'b1;
          busy <= 1'b0;
          cost <= '0;
        end
        default: ;
      endcase
    end
  end

  // Positions are only meaningful where placed[] is set, so they carry no reset.
  always_ff @(posedge clk) begin
    if (state == S_PLACE && cand_ok) begin
      pos_x[tgt] <= cand_x;
      pos_y[tgt] <= cand_y;
    end
  end

`ifdef ONEHOP_EVAL_EN
  logic [CW-1:0] ev_c1;
  assign ev_c1 = CW'(((e_dx + 1) >> 1) + ((e_dy + 1) >> 1) - 1);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset)                             cost_1hop <= '0;
    else if (state == S_IDLE && start)      cost_1hop <= '0;
    else if (state == S_FAIL)               cost_1hop <= '0;
    else if (state == S_EVAL_ACC)           cost_1hop <= cost_1hop + ev_c1;
  end
`else
  assign cost_1hop = '0;
`endif

endmodule
